// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Byte FIFO sitting behind a UART receiver. The receiver's rx_valid flag
//   is asynchronous to clk. It is synchronised, and its rising edge writes
//   rx_data into the FIFO. The consumer side is show-ahead: dout presents
//   the head byte, and rd_en pops it.
//
// Parameters
//   DEPTH     number of entries. Must be a power of two in the range 2..64.
//
// Ports
//   clk       system clock, at least 4x the upstream baud rate
//   rst_n     asynchronous active-low reset
//   rx_data   received byte, stable while rx_valid is high
//   rx_valid  receiver valid pulse, asynchronous to clk
//   rd_en     pop request, sampled on the rising edge of clk
//   dout      head-of-FIFO byte, or 8'h00 when empty
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   count     current occupancy, 0..DEPTH
//   ovf_clr   clears the overflow flag (UART_RX_FIFO_OVF_EN only)
//   overflow  sticky flag: a byte was dropped (UART_RX_FIFO_OVF_EN only)
//
// Build option
//   UART_RX_FIFO_OVF_EN  When defined, adds the ovf_clr/overflow ports and
//                        the sticky drop flag. Without it, drops are silent.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rd_en,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef UART_RX_FIFO_OVF_EN
  ,
  input  logic                     ovf_clr,
  output logic                     overflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          s1_q, s2_q, s3_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic wr_evt;   // rising edge of synchronised rx_valid
  logic rd_acc;   // pop accepted
  logic wr_acc;   // push accepted

  // The synchroniser resets to 1. This way a pulse that is already high when
  // reset is released looks like a level, not an edge, and is not captured.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= rx_valid;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign wr_evt = s2_q & ~s3_q;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;

  // A pop is only honoured when there is data. A push into a full FIFO is
  // accepted only when a pop on the same edge frees the slot.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_evt & (~full | rd_acc);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset. Its contents are only observable
  // through count/rd_ptr, and those are reset, so the stale bytes are
  // unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= rx_data;
  end

  assign dout = empty ? 8'h00 : mem_q[rd_ptr_q];

`ifdef UART_RX_FIFO_OVF_EN
  logic overflow_q, overflow_d;
  logic drop;

  // A drop wins over a coincident clear, so a lost byte is never hidden.
  assign drop = wr_evt & full & ~rd_acc;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo with DEPTH=8. Inputs are
//   driven, and outputs sampled, 1 time unit after each rising clock edge.
//   The overflow checks are compiled in only when UART_RX_FIFO_OVF_EN is set.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_en;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
`ifdef UART_RX_FIFO_OVF_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(.DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rd_en    (rd_en),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count)
`ifdef UART_RX_FIFO_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds rx_valid high for 4 clocks, then low for 3 clocks. The write lands
  // on the 3rd edge after the rise. If rd_at_wr is set, rd_en is high for
  // that edge only.
  task automatic pulse(input logic [7:0] b, input bit rd_at_wr);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    tick();
    if (rd_at_wr) rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rd_en    = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
    ovf_clr  = 1'b0;
`endif
    #12;
    // State while reset is asserted
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);
    check("rst_dout",  dout,  8'h00);
`ifdef UART_RX_FIFO_OVF_EN
    check("rst_ovf", overflow, 0);
`endif
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // A single long pulse: empty falls on the 3rd edge, and only one entry
    // is written.
    rx_data  = 8'h5A;
    rx_valid = 1'b1;
    tick();
    check("lat_e1_empty", empty, 1);
    tick();
    check("lat_e2_empty", empty, 1);
    tick();
    check("lat_e3_empty", empty, 0);
    check("lat_dout", dout, 8'h5A);
    check("lat_count", count, 1);
    repeat (5) tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    check("long_pulse_count", count, 1);

    // Fill with 01..08, then drain in order.
    do_reset();
    for (int i = 1; i <= 8; i++) pulse(8'(i), 1'b0);
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_dout%0d", i), dout, i);
      tick();
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_dout_zero", dout, 8'h00);
    check("drain_count", count, 0);
    // A pop on an empty FIFO is ignored.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("pop_empty_count", count, 0);

    // Write into a full FIFO with no pop: the byte is dropped.
    for (int i = 0; i < 8; i++) pulse(8'h10 + 8'(i), 1'b0);
    pulse(8'hFF, 1'b0);
    check("drop_count", count, 8);
    check("drop_full", full, 1);
    check("drop_head", dout, 8'h10);
`ifdef UART_RX_FIFO_OVF_EN
    check("drop_ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
`endif
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drop_drain%0d", i), dout, 8'h10 + i);
      tick();
    end
    rd_en = 1'b0;
    check("drop_drain_empty", empty, 1);

    // Full FIFO, with a write coinciding with a pop.
    for (int i = 0; i < 8; i++) pulse(8'h20 + 8'(i), 1'b0);
    pulse(8'h99, 1'b1);
    check("wr_rd_full_count", count, 8);
    check("wr_rd_full_full", full, 1);
    check("wr_rd_full_head", dout, 8'h21);
`ifdef UART_RX_FIFO_OVF_EN
    check("wr_rd_full_ovf", overflow, 0);
`endif
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("wr_rd_drain%0d", i), dout, (i == 8) ? 8'h99 : 8'h20 + i);
      tick();
    end
    rd_en = 1'b0;
    check("wr_rd_drain_empty", empty, 1);

    // Empty FIFO with rd_en held high across a write.
    rd_en    = 1'b1;
    rx_data  = 8'hA3;
    rx_valid = 1'b1;
    tick();
    check("rdhold_e1_count", count, 0);
    tick();
    check("rdhold_e2_count", count, 0);
    tick();
    check("rdhold_wr_count", count, 1);
    check("rdhold_wr_dout", dout, 8'hA3);
    tick();
    check("rdhold_pop_count", count, 0);
    check("rdhold_pop_empty", empty, 1);
    rd_en    = 1'b0;
    rx_valid = 1'b0;
    repeat (3) tick();

    // Reset in mid-operation with rx_valid high, then released while
    // rx_valid is still high.
    pulse(8'h77, 1'b0);
    check("pre_rst_count", count, 1);
    rx_data  = 8'h3C;
    rx_valid = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_dout", dout, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("rel_high_count", count, 0);
    check("rel_high_empty", empty, 1);
    rx_valid = 1'b0;
    repeat (3) tick();
    pulse(8'h3C, 1'b0);
    check("after_rel_count", count, 1);
    check("after_rel_dout", dout, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
